// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressed data memory.
// Holds FSM states, access-size codes and load extension.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int MAX_DW = 64;

  // Keeps the low nbytes*bw bits; fills above with the top kept bit or 0.
  function automatic logic [MAX_DW-1:0] sign_extend(
    input logic [MAX_DW-1:0] data,
    input int                nbytes,
    input int                bw,
    input logic              sgn
  );
    logic [MAX_DW-1:0] r;
    int                top;
    logic              msb;
    top = nbytes * bw;
    msb = sgn & data[top-1];
    r   = '0;
    for (int i = 0; i < MAX_DW; i++) begin
      r[i] = (i < top) ? data[i] : msb;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Byte-wide storage array for the data memory.
// Synchronous write port, asynchronous read port, no reset.
module dmem_byte_ram #(
  parameter int ADDR_W = 8,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BYTE_W-1:0] wdata,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/byte_data_memory.sv
// Big-endian byte/half/word data memory, one byte moved per cycle.
// Request and response channels use valid/ready handshakes.
module byte_data_memory
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int BYTE_W     = 8,
  parameter int WORD_BYTES = 4,
  parameter int SIZE_W     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [SIZE_W-1:0]            req_size,
  input  logic                         req_signed,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [WORD_BYTES*BYTE_W-1:0] req_wdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [WORD_BYTES*BYTE_W-1:0] rsp_rdata,
  output logic                         rsp_err
);

  localparam int DW     = WORD_BYTES * BYTE_W;
  localparam int LOG_WB = $clog2(WORD_BYTES);
  localparam int CNT_W  = (LOG_WB > 0) ? LOG_WB : 1;

  state_t state, state_n;

  logic              we_q, sgn_q, err_q;
  logic [CNT_W:0]    n_q, bidx;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q, ram_addr;
  logic [DW-1:0]     wdata_q, acc;
  logic [BYTE_W-1:0] ram_wdata, ram_rdata;
  logic              ram_we, accept, last, size_bad;
  logic [MAX_DW-1:0] ext;

  assign accept   = req_valid & req_ready;
  assign size_bad = int'(req_size) > LOG_WB;
  assign last     = ({1'b0, cnt} == n_q - (CNT_W+1)'(1));

  // Byte k of the access is byte n-1-k of the right-justified store data.
  assign bidx      = n_q - (CNT_W+1)'(1) - {1'b0, cnt};
  assign ram_addr  = addr_q + ADDR_W'(cnt);
  assign ram_wdata = BYTE_W'(wdata_q >> (int'(bidx) * BYTE_W));
  assign ram_we    = (state == XFER) & we_q;

  dmem_byte_ram #(
    .ADDR_W (ADDR_W),
    .BYTE_W (BYTE_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept)    state_n = size_bad ? RESP : XFER;
      XFER: if (last)      state_n = RESP;
      RESP: if (rsp_ready) state_n = IDLE;
      default:             state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      n_q     <= '0;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      acc     <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      sgn_q   <= req_signed;
      err_q   <= size_bad;
      n_q     <= (CNT_W+1)'(1) << req_size;
      cnt     <= '0;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      acc     <= '0;
    end else if (state == XFER) begin
      cnt <= cnt + 1'b1;
      if (!we_q) acc <= (acc << BYTE_W) | DW'(ram_rdata);
    end
  end

  assign ext       = sign_extend(MAX_DW'(acc), int'(n_q), BYTE_W, sgn_q);
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = (rsp_valid & ~we_q & ~err_q) ? ext[DW-1:0] : '0;

endmodule

// File: tb/tb_byte_data_memory.sv
// Scoreboard bench for byte_data_memory.
// Expected responses are queued at issue and checked on rsp_valid.
module tb_byte_data_memory;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int ncmp = 0;
  int nbad = 0;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  byte_data_memory dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(string tag, logic we, logic [1:0] size, logic sgn,
                      logic [7:0] addr, logic [31:0] wd,
                      logic [31:0] er, logic ee);
    exp_t e;
    @(negedge clk);
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    e.tag   = tag;
    e.rdata = er;
    e.err   = ee;
    e.lat   = ee ? 1 : (1 << size) + 1;
    sbq.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Latency counts edges from accept to the first edge that sees rsp_valid.
  task automatic collect(int hold);
    exp_t e;
    int   lat;
    logic seen;
    e    = sbq.pop_front();
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) seen = 1'b1;
    end
    check({e.tag, " rsp_valid"}, 32'(seen), 32'd1);
    if (!seen) return;
    check({e.tag, " latency"}, 32'(lat), 32'(e.lat));
    check({e.tag, " rdata"}, rsp_rdata, e.rdata);
    check({e.tag, " err"}, 32'(rsp_err), 32'(e.err));
    if (hold > 0) begin
      req_we    = 1'b1;
      req_size  = SZ_BYTE;
      req_addr  = 8'h10;
      req_wdata = 32'h99;
      req_valid = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check({e.tag, " hold valid"}, 32'(rsp_valid), 32'd1);
        check({e.tag, " hold rdata"}, rsp_rdata, e.rdata);
        check({e.tag, " hold err"}, 32'(rsp_err), 32'(e.err));
        check({e.tag, " hold req_ready"}, 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1 check({e.tag, " rsp drop"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic xact(string tag, logic we, logic [1:0] size, logic sgn,
                      logic [7:0] addr, logic [31:0] wd,
                      logic [31:0] er, logic ee);
    send(tag, we, size, sgn, addr, wd, er, ee);
    collect(0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        seen;
    logic [1:0]  sz;
    logic [7:0]  ad;
    logic [31:0] wd, mask, val;
    logic        sg;
    int          n;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = '0;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b1;
    repeat (2) @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;

    xact("st_w10", 1, SZ_WORD, 0, 8'h10, 32'h11223344, 32'h0, 0);
    xact("ld_w10", 0, SZ_WORD, 0, 8'h10, 32'h0, 32'h11223344, 0);
    xact("ld_b10", 0, SZ_BYTE, 0, 8'h10, 32'h0, 32'h11, 0);
    xact("ld_b13", 0, SZ_BYTE, 0, 8'h13, 32'h0, 32'h44, 0);

    xact("st_h21", 1, SZ_HALF, 0, 8'h21, 32'h0000BEEF, 32'h0, 0);
    xact("ld_h21s", 0, SZ_HALF, 1, 8'h21, 32'h0, 32'hFFFFBEEF, 0);
    xact("ld_h21u", 0, SZ_HALF, 0, 8'h21, 32'h0, 32'h0000BEEF, 0);
    xact("ld_b21", 0, SZ_BYTE, 0, 8'h21, 32'h0, 32'hBE, 0);
    xact("ld_b22", 0, SZ_BYTE, 0, 8'h22, 32'h0, 32'hEF, 0);
    xact("ld_b22s", 0, SZ_BYTE, 1, 8'h22, 32'h0, 32'hFFFFFFEF, 0);

    xact("st_wfe", 1, SZ_WORD, 0, 8'hFE, 32'hA1B2C3D4, 32'h0, 0);
    xact("ld_bfe", 0, SZ_BYTE, 0, 8'hFE, 32'h0, 32'hA1, 0);
    xact("ld_bff", 0, SZ_BYTE, 0, 8'hFF, 32'h0, 32'hB2, 0);
    xact("ld_b00", 0, SZ_BYTE, 0, 8'h00, 32'h0, 32'hC3, 0);
    xact("ld_b01", 0, SZ_BYTE, 0, 8'h01, 32'h0, 32'hD4, 0);
    xact("ld_wfe", 0, SZ_WORD, 1, 8'hFE, 32'h0, 32'hA1B2C3D4, 0);

    xact("st_b30", 1, SZ_BYTE, 0, 8'h30, 32'h5A, 32'h0, 0);
    xact("st_bad", 1, 2'd3, 0, 8'h30, 32'hFFFFFFFF, 32'h0, 1);
    xact("ld_bad", 0, 2'd3, 1, 8'h30, 32'h0, 32'h0, 1);
    xact("ld_b30", 0, SZ_BYTE, 0, 8'h30, 32'h0, 32'h5A, 0);

    send("ld_stall", 0, SZ_WORD, 0, 8'h10, 32'h0, 32'h11223344, 0);
    rsp_ready = 1'b0;
    collect(4);
    xact("ld_b10_post", 0, SZ_BYTE, 0, 8'h10, 32'h0, 32'h11, 0);

    xact("st_w40", 1, SZ_WORD, 0, 8'h40, 32'h55667788, 32'h0, 0);
    @(negedge clk);
    req_we    = 1'b1;
    req_size  = SZ_WORD;
    req_addr  = 8'h40;
    req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort req_ready", 32'(req_ready), 32'd1);
    check("abort rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort rsp_rdata", rsp_rdata, 32'd0);
    check("abort rsp_err", 32'(rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("abort no rsp", 32'(seen), 32'd0);
    xact("ld_b40", 0, SZ_BYTE, 0, 8'h40, 32'h0, 32'hCA, 0);
    xact("ld_b41", 0, SZ_BYTE, 0, 8'h41, 32'h0, 32'hFE, 0);
    xact("ld_b42", 0, SZ_BYTE, 0, 8'h42, 32'h0, 32'h77, 0);
    xact("ld_b43", 0, SZ_BYTE, 0, 8'h43, 32'h0, 32'h88, 0);

    for (int r = 0; r < 6; r++) begin
      sz   = 2'($urandom_range(0, 2));
      ad   = 8'($urandom);
      wd   = $urandom;
      sg   = 1'($urandom);
      n    = 1 << sz;
      mask = (n == 4) ? 32'hFFFFFFFF : (32'd1 << (8 * n)) - 32'd1;
      val  = wd & mask;
      if (sg && val[8*n-1]) val = val | ~mask;
      xact("rnd_st", 1, sz, 0, ad, wd, 32'h0, 0);
      xact("rnd_ld", 0, sz, sg, ad, 32'h0, val, 0);
    end

    check("sb empty", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
